// File: rtl/fft_pkg.sv
// fft_pkg: shared defaults, sequencer state encoding and bit-reverse helper for the FFT control path.
package fft_pkg;

    localparam int SIZE_DEF  = 64;
    localparam int LOG2N_DEF = 6;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ADVANCE, FIN, BITREV} state_t;

    function automatic logic [31:0] bitrev(input logic [31:0] x, input int bits);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 32; b++)
            if (b < bits) r[b] = x[bits-1-b];
        return r;
    endfunction

endpackage

// File: rtl/fft_index_gen.sv
// fft_index_gen: stage/group/offset counters for the DIF butterfly walk; last_bfly flags the final butterfly.
module fft_index_gen
    import fft_pkg::*;
#(
    parameter int SIZE  = SIZE_DEF,
    parameter int LOG2N = LOG2N_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             adv,
    output logic [LOG2N:0]   s,
    output logic [LOG2N:0]   g,
    output logic [LOG2N:0]   k,
    output logic             last_bfly
);
    localparam int W = LOG2N + 1;

    logic [W-1:0] span, span2;
    logic k_last, g_last, s_last;

    assign span      = W'(SIZE) >> s;
    assign span2     = span << 1;
    assign k_last    = k + W'(1) == span;
    assign g_last    = g + span2 == W'(SIZE);
    assign s_last    = s == W'(LOG2N);
    assign last_bfly = k_last & g_last & s_last;

    // On the final butterfly the counters hold; the sequencer leaves for FIN.
    always_ff @(posedge clk) begin
        if (rst || load) begin
            s <= W'(1);
            g <= '0;
            k <= '0;
        end else if (adv) begin
            if (!k_last) k <= k + W'(1);
            else if (!g_last) begin
                g <= g + span2;
                k <= '0;
            end else if (!s_last) begin
                s <= s + W'(1);
                g <= '0;
                k <= '0;
            end
        end
    end

endmodule

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: issues radix-2 DIF butterfly requests stage by stage and waits for each completion.
// Defining FFT_BITREV_PASS_EN appends a bit-reverse swap pass so results come out in natural order.
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int SIZE  = SIZE_DEF,
    parameter int LOG2N = LOG2N_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] n,
    output logic [31:0] p,
    output logic [31:0] counter,
    output logic        bfly_start,
    input  logic        bfly_done,
    output logic        swap_valid,
    output logic [31:0] swap_a,
    output logic [31:0] swap_b,
    input  logic        swap_done
);
    localparam int W = LOG2N + 1;

    state_t       state, state_n;
    logic         start_q, load, adv, last_bfly;
    logic [W-1:0] s, g, k;

    fft_index_gen #(.SIZE(SIZE), .LOG2N(LOG2N)) u_idx (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .adv       (adv),
        .s         (s),
        .g         (g),
        .k         (k),
        .last_bfly (last_bfly)
    );

    assign n       = 32'(g + k);
    assign p       = 32'(s);
    assign counter = 32'(k);

    // start is edge-qualified so a level held across a whole transform launches it only once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            start_q <= 1'b0;
        end else begin
            state   <= state_n;
            start_q <= start;
        end
    end

`ifdef FFT_BITREV_PASS_EN
    logic [W-1:0] bi, bi_n, br;
    logic         bw, bw_n;

    assign br     = W'(bitrev(32'(bi), LOG2N));
    assign swap_a = state == BITREV ? 32'(bi) : '0;
    assign swap_b = state == BITREV ? 32'(br) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            bi <= '0;
            bw <= 1'b0;
        end else begin
            bi <= bi_n;
            bw <= bw_n;
        end
    end
`else
    logic unused_swap_done;
    assign unused_swap_done = swap_done;
    assign swap_valid       = 1'b0;
    assign swap_a           = '0;
    assign swap_b           = '0;
`endif

    always_comb begin
        state_n    = state;
        load       = 1'b0;
        adv        = 1'b0;
        bfly_start = 1'b0;
        done       = 1'b0;
        busy       = 1'b0;
`ifdef FFT_BITREV_PASS_EN
        swap_valid = 1'b0;
        bi_n       = bi;
        bw_n       = bw;
`endif
        case (state)
            IDLE: begin
                if (start && !start_q) begin
                    load    = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                busy       = 1'b1;
                bfly_start = 1'b1;
                state_n    = WAIT;
            end
            WAIT: begin
                busy    = 1'b1;
                state_n = bfly_done ? ADVANCE : WAIT;
            end
            ADVANCE: begin
                busy    = 1'b1;
                adv     = 1'b1;
                state_n = last_bfly ? FIN : ISSUE;
            end
            FIN: begin
`ifdef FFT_BITREV_PASS_EN
                busy    = 1'b1;
                bi_n    = '0;
                bw_n    = 1'b0;
                state_n = BITREV;
`else
                done    = 1'b1;
                state_n = IDLE;
`endif
            end
`ifdef FFT_BITREV_PASS_EN
            // Each index either skips (i >= r) or issues one swap and waits for its completion.
            BITREV: begin
                busy = 1'b1;
                if ((bw && swap_done) || (!bw && bi >= br)) begin
                    bw_n = 1'b0;
                    if (bi == W'(SIZE - 1)) begin
                        done    = 1'b1;
                        busy    = 1'b0;
                        state_n = IDLE;
                    end else bi_n = bi + W'(1);
                end else if (!bw) begin
                    swap_valid = 1'b1;
                    bw_n       = 1'b1;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    bfly_done_in_issue: assert property (@(posedge clk) disable iff (rst) !(state == ISSUE && bfly_done));

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// tb_fft_stage_sequencer: directed checks of the butterfly sequencer at SIZE=8 and the default SIZE=64.
module tb_fft_stage_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start[2], bfly_done[2], swap_done[2];
    logic        busy[2], done[2], bfly_start[2], swap_valid[2];
    logic [31:0] n[2], p[2], counter[2], swap_a[2], swap_b[2];

    int checks = 0;
    int fails  = 0;
    int lat[2], resp_left[2], nreq[2], ndone[2], span_err[2], swap_err[2], nswap[2];
    bit force_done[2];
    logic [31:0] rq_n[$], rq_p[$], rq_c[$], sw_a[$], sw_b[$];

    typedef struct {
        int          idx;
        logic [31:0] n, p, c;
    } req_t;
    req_t exp8[12];

    always #5 clk = ~clk;

    fft_stage_sequencer #(.SIZE(8), .LOG2N(3)) d8 (
        .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .n(n[0]), .p(p[0]), .counter(counter[0]), .bfly_start(bfly_start[0]), .bfly_done(bfly_done[0]),
        .swap_valid(swap_valid[0]), .swap_a(swap_a[0]), .swap_b(swap_b[0]), .swap_done(swap_done[0])
    );

    fft_stage_sequencer d64 (
        .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .n(n[1]), .p(p[1]), .counter(counter[1]), .bfly_start(bfly_start[1]), .bfly_done(bfly_done[1]),
        .swap_valid(swap_valid[1]), .swap_a(swap_a[1]), .swap_b(swap_b[1]), .swap_done(swap_done[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Datapath model: answers each request lat cycles later, answers swaps after one cycle, logs traffic.
    task automatic responder(input int d);
        int pend = 0;
        int spend = 0;
        int sz = d ? 64 : 8;
        forever begin
            @(negedge clk);
            bfly_done[d] = 1'b0;
            swap_done[d] = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) bfly_done[d] = 1'b1;
            end
            if (force_done[d]) begin
                bfly_done[d]  = 1'b1;
                force_done[d] = 1'b0;
            end
            if (spend > 0) begin
                spend--;
                if (spend == 0) swap_done[d] = 1'b1;
            end
            if (rst) begin
                pend  = 0;
                spend = 0;
            end
            if (done[d]) ndone[d]++;
            if (bfly_start[d]) begin
                nreq[d]++;
                if (d == 0) begin
                    rq_n.push_back(n[d]);
                    rq_p.push_back(p[d]);
                    rq_c.push_back(counter[d]);
                end
                if (p[d] < 1 || n[d] + 32'(sz >> p[d]) > 32'(sz - 1) || counter[d] > 32'(sz / 2 - 1))
                    span_err[d]++;
                if (resp_left[d] > 0) begin
                    resp_left[d]--;
                    pend = lat[d];
                end
            end
            if (swap_valid[d]) begin
                nswap[d]++;
                spend = 1;
                if (d == 0) begin
                    sw_a.push_back(swap_a[d]);
                    sw_b.push_back(swap_b[d]);
                end
            end
            if (!swap_valid[d] && busy[d] && (swap_a[d] > swap_b[d])) swap_err[d]++;
`ifndef FFT_BITREV_PASS_EN
            if (swap_a[d] != 0 || swap_b[d] != 0) swap_err[d]++;
`endif
        end
    endtask

    // Caller sets start at a falling edge; cyc counts that cycle through the done cycle inclusive.
    task automatic wait_done(input int d, input int bound, input bit hold, output int cyc);
        cyc = 1;
        while (done[d] !== 1'b1 && cyc <= bound) begin
            @(negedge clk);
            if (!hold) start[d] = 1'b0;
            cyc++;
        end
        check($sformatf("done_seen_d%0d", d), 32'(done[d]), 1);
    endtask

    initial responder(0);
    initial responder(1);

    initial begin
        int cyc, unstable, bs_cnt;
        logic [31:0] hn, hp, hc;
        exp8 = '{'{0, 0, 1, 0}, '{1, 1, 1, 1}, '{2, 2, 1, 2}, '{3, 3, 1, 3},
                 '{4, 0, 2, 0}, '{5, 1, 2, 1}, '{6, 4, 2, 0}, '{7, 5, 2, 1},
                 '{8, 0, 3, 0}, '{9, 2, 3, 0}, '{10, 4, 3, 0}, '{11, 6, 3, 0}};
        for (int d = 0; d < 2; d++) begin
            start[d] = 0; bfly_done[d] = 0; swap_done[d] = 0; force_done[d] = 0;
            lat[d] = 1; resp_left[d] = 0; nreq[d] = 0; ndone[d] = 0;
            span_err[d] = 0; swap_err[d] = 0; nswap[d] = 0;
        end
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy[0]), 0);
        check("rst_done", 32'(done[0]), 0);
        check("rst_bfly_start", 32'(bfly_start[0]), 0);
        check("rst_n", n[0], 0);
        check("rst_p", p[0], 1);
        check("rst_counter", counter[0], 0);
        check("rst_swap_valid", 32'(swap_valid[0]), 0);
        check("rst_swap_a", swap_a[0], 0);
        check("rst_swap_b", swap_b[0], 0);
        rst = 0;
        @(negedge clk);

        // SIZE=8, two-cycle datapath: request order against the table
        lat[0] = 2; resp_left[0] = 1000; start[0] = 1;
        wait_done(0, 2000, 0, cyc);
        @(negedge clk);
        check("a_busy_after", 32'(busy[0]), 0);
        repeat (3) @(negedge clk);
        check("a_nreq", nreq[0], 12);
        check("a_ndone", ndone[0], 1);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("req%0d_n", exp8[i].idx), rq_n[i], exp8[i].n);
            check($sformatf("req%0d_p", exp8[i].idx), rq_p[i], exp8[i].p);
            check($sformatf("req%0d_counter", exp8[i].idx), rq_c[i], exp8[i].c);
        end
`ifdef FFT_BITREV_PASS_EN
        check("a_nswap", nswap[0], 2);
        check("swap0_a", sw_a[0], 1);
        check("swap0_b", sw_b[0], 4);
        check("swap1_a", sw_a[1], 3);
        check("swap1_b", sw_b[1], 6);
`else
        check("a_nswap", nswap[0], 0);
        check("a_swap_err", swap_err[0], 0);
`endif

        // SIZE=64, single-cycle datapath: count and timing
        lat[1] = 1; resp_left[1] = 1000; start[1] = 1;
        wait_done(1, 3000, 0, cyc);
`ifdef FFT_BITREV_PASS_EN
        check("b_cycles", cyc, 192 * 3 + 2 + 64 + 28);
`else
        check("b_cycles", cyc, 192 * 3 + 2);
`endif
        @(negedge clk);
        check("b_busy_after", 32'(busy[1]), 0);
        check("b_nreq", nreq[1], 192);
        check("b_span_err", span_err[1], 0);
        check("a_span_err", span_err[0], 0);

        // start held high: exactly one transform until re-pulsed
        nreq[0] = 0; ndone[0] = 0; lat[0] = 1; resp_left[0] = 1000; start[0] = 1;
        wait_done(0, 2000, 1, cyc);
        repeat (10) @(negedge clk);
        check("c_held_nreq", nreq[0], 12);
        check("c_held_ndone", ndone[0], 1);
        check("c_held_busy", 32'(busy[0]), 0);
        start[0] = 0;
        @(negedge clk);
        start[0] = 1;
        @(negedge clk);
        check("c_restart_bfly_start", 32'(bfly_start[0]), 1);
        wait_done(0, 2000, 0, cyc);

        // reset while stalled in stage 2, then a stray completion
        repeat (2) @(negedge clk);
        nreq[0] = 0; ndone[0] = 0; resp_left[0] = 5; start[0] = 1;
        @(negedge clk);
        start[0] = 0;
        for (int i = 0; i < 200 && nreq[0] < 6; i++) begin
            @(negedge clk);
            #1;
        end
        check("d_stall_nreq", nreq[0], 6);
        repeat (2) @(negedge clk);
        check("d_stall_p", p[0], 2);
        check("d_stall_busy", 32'(busy[0]), 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("d_rst_busy", 32'(busy[0]), 0);
        check("d_rst_n", n[0], 0);
        check("d_rst_p", p[0], 1);
        check("d_rst_counter", counter[0], 0);
        check("d_rst_bfly_start", 32'(bfly_start[0]), 0);
        force_done[0] = 1;
        repeat (5) @(negedge clk);
        #1;
        check("d_after_nreq", nreq[0], 6);
        check("d_after_ndone", ndone[0], 0);
        check("d_after_busy", 32'(busy[0]), 0);
        resp_left[0] = 1000; start[0] = 1;
        @(negedge clk);
        start[0] = 0;
        check("d_fresh_bfly_start", 32'(bfly_start[0]), 1);
        check("d_fresh_n", n[0], 0);
        check("d_fresh_p", p[0], 1);
        check("d_fresh_counter", counter[0], 0);
        wait_done(0, 2000, 0, cyc);

        // 50-cycle datapath stall: outputs held, one request pulse
        repeat (2) @(negedge clk);
        lat[0] = 50; resp_left[0] = 1000; start[0] = 1;
        @(negedge clk);
        #1;
        start[0] = 0;
        hn = n[0]; hp = p[0]; hc = counter[0];
        bs_cnt = int'(bfly_start[0]);
        unstable = 0;
        for (int i = 1; i < 50; i++) begin
            @(negedge clk);
            #1;
            if (i == 5) lat[0] = 1;
            if (n[0] !== hn || p[0] !== hp || counter[0] !== hc) unstable++;
            bs_cnt += int'(bfly_start[0]);
        end
        check("e_unstable", unstable, 0);
        check("e_bfly_start_pulses", bs_cnt, 1);
        check("e_busy", 32'(busy[0]), 1);
        wait_done(0, 2000, 0, cyc);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
